// File: rtl/bpm_pkg.sv
// bpm_pkg: frame geometry defaults and framer FSM states shared by the BPM front end
package bpm_pkg;
  localparam int DEF_W = 16;
  localparam int DEF_N = 1024;
  localparam int DEF_HOP = 512;
  localparam int DEF_IDX_W = 10;
  typedef enum logic [1:0] {FILL, EMIT, HOP_WAIT} state_t;
endpackage

// File: rtl/overlap_frame_buffer_frame_ram.sv
// frame_ram: N x W simple dual-port RAM, synchronous write, registered read, contents not reset
module frame_ram import bpm_pkg::*; #(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);
  logic [W-1:0] r_mem [N];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/overlap_frame_buffer.sv
// overlap_frame_buffer: N-sample circular buffer that emits the newest N samples, oldest first,
// after the initial fill and then after every HOP further samples.
module overlap_frame_buffer import bpm_pkg::*; #(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  parameter int HOP = DEF_HOP,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_sample,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sample_out,
  output logic [IDX_W-1:0] sample_index,
  output logic             frame_start,
  output logic             frame_last,
  output logic [15:0]      frame_count
);
  localparam logic [IDX_W-1:0] N_M1 = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] HOP_M1 = IDX_W'(HOP - 1);
  state_t r_state, w_state_nxt;
  logic [IDX_W-1:0] r_wr_ptr, r_cnt, r_s1_idx, r_idx;
  logic [IDX_W:0] r_rd_cnt;
  logic r_s1_v, r_out_valid, r_first, r_last;
  logic [W-1:0] r_sample, w_rdata;
  logic [15:0] r_fcnt;
  logic w_in_acc, w_in_done, w_adv, w_rd, w_last_xfer;
  // Read pipeline: RAM read stage then output register; both stall together under backpressure.
  always_comb begin
    in_ready = !reset && r_state != EMIT;
    w_in_acc = in_valid && in_ready;
    w_in_done = w_in_acc && r_cnt == (r_state == FILL ? N_M1 : HOP_M1);
    w_adv = !r_out_valid || out_ready;
    w_rd = w_adv && r_state == EMIT && !r_rd_cnt[IDX_W];
    w_last_xfer = r_out_valid && out_ready && r_last;
    w_state_nxt = w_in_done ? EMIT : w_last_xfer ? HOP_WAIT : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
      r_wr_ptr <= '0;
      r_cnt <= '0;
      r_rd_cnt <= '0;
      r_s1_v <= 1'b0;
      r_s1_idx <= '0;
      r_out_valid <= 1'b0;
      r_sample <= '0;
      r_idx <= '0;
      r_first <= 1'b0;
      r_last <= 1'b0;
      r_fcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_acc) begin
        r_wr_ptr <= r_wr_ptr + IDX_W'(1);
        r_cnt <= w_in_done ? '0 : r_cnt + IDX_W'(1);
      end
      if (w_adv) begin
        r_s1_v <= w_rd;
        r_s1_idx <= r_rd_cnt[IDX_W-1:0];
        r_out_valid <= r_s1_v;
        r_first <= r_s1_v && r_s1_idx == '0;
        r_last <= r_s1_v && r_s1_idx == N_M1;
        if (r_s1_v) begin
          r_sample <= w_rdata;
          r_idx <= r_s1_idx;
        end
      end
      if (w_rd) r_rd_cnt <= r_rd_cnt + (IDX_W+1)'(1);
      if (w_last_xfer) begin
        r_rd_cnt <= '0;
        r_fcnt <= r_fcnt + 16'd1;
      end
    end
  end
  frame_ram #(.W(W), .N(N), .IDX_W(IDX_W)) u_ram (
    .clk(clk),
    .i_we(w_in_acc),
    .i_waddr(r_wr_ptr),
    .i_wdata(in_sample),
    .i_re(w_rd),
    .i_raddr(r_wr_ptr + r_rd_cnt[IDX_W-1:0]),
    .o_rdata(w_rdata)
  );
  assign out_valid = r_out_valid;
  assign sample_out = r_sample;
  assign sample_index = r_idx;
  assign frame_start = r_first;
  assign frame_last = r_last;
  assign frame_count = r_fcnt;
endmodule

// File: tb/tb_overlap_frame_buffer.sv
// tb_overlap_frame_buffer: directed checks of overlapping frame output for N=8 HOP=4, HOP=N and default sizes
module tb_overlap_frame_buffer;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid, frame_start, frame_last;
  logic [15:0] in_sample = '0, sample_out, frame_count;
  logic [2:0] sample_index;
  logic h_in_valid = 1'b0, h_out_ready = 1'b1, h_in_ready, h_out_valid, h_fs, h_fl;
  logic [15:0] h_in_sample = '0, h_sample_out, h_fc;
  logic [2:0] h_idx;
  logic d_in_valid = 1'b0, d_out_ready = 1'b1, d_in_ready, d_out_valid, d_fs, d_fl;
  logic [15:0] d_in_sample = '0, d_sample_out, d_fc;
  logic [9:0] d_idx;
  logic [15:0] cv [16];
  logic [2:0] ci [16];
  logic [7:0] cfs, cfl;
  int got, ir;

  overlap_frame_buffer #(.W(16), .N(8), .HOP(4), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .sample_out(sample_out), .sample_index(sample_index),
    .frame_start(frame_start), .frame_last(frame_last), .frame_count(frame_count));
  overlap_frame_buffer #(.W(16), .N(8), .HOP(8), .IDX_W(3)) dut_h (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_sample(h_in_sample), .in_ready(h_in_ready),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .sample_out(h_sample_out), .sample_index(h_idx),
    .frame_start(h_fs), .frame_last(h_fl), .frame_count(h_fc));
  overlap_frame_buffer dut_d (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_sample(d_in_sample), .in_ready(d_in_ready),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .sample_out(d_sample_out), .sample_index(d_idx),
    .frame_start(d_fs), .frame_last(d_fl), .frame_count(d_fc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_sample = 16'(v);
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL feed_timeout sample=%0d in_ready=%b want 1", v, in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Gathers up to 8 transfers of the main DUT with out_ready high; got < 8 means the bound expired.
  task automatic collect();
    got = 0;
    ir = 0;
    cfs = '0;
    cfl = '0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && got < 8; t++) begin
      if (in_ready) ir++;
      if (out_valid) begin
        cv[got] = sample_out;
        ci[got] = sample_index;
        cfs[got] = frame_start;
        cfl[got] = frame_last;
        got++;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_vec++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b want 0", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0 || frame_start !== 1'b0 || frame_last !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got=%b%b%b want 000", out_valid, frame_start, frame_last);
    end
    n_vec++;
    if (sample_out !== 16'd0 || sample_index !== 3'd0 || frame_count !== 16'd0) begin
      n_bad++; $display("FAIL reset_regs got=%0d/%0d/%0d want 0/0/0", sample_out, sample_index, frame_count);
    end
    n_vec++;
    if (h_out_valid !== 1'b0 || d_out_valid !== 1'b0 || h_fc !== 16'd0 || d_fc !== 16'd0) begin
      n_bad++; $display("FAIL reset_other got=%b%b/%0d/%0d want 00/0/0", h_out_valid, d_out_valid, h_fc, d_fc);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got=%b want 1", in_ready); end
  endtask

  task automatic test_first_frame();
    for (int k = 1; k <= 8; k++) feed(k);
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_edge0 out_valid=%b want 0", out_valid); end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_edge1 out_valid=%b want 0", out_valid); end
    step();
    n_vec++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_edge2 out_valid=%b want 1", out_valid); end
    collect();
    n_vec++;
    if (got !== 8) begin n_bad++; $display("FAIL f1_count got=%0d want 8", got); end
    for (int i = 0; i < got; i++) begin
      n_vec++;
      if (cv[i] !== 16'(i + 1) || ci[i] !== 3'(i)) begin
        n_bad++; $display("FAIL f1_data[%0d] got=%0d/idx%0d want %0d/idx%0d", i, cv[i], ci[i], i + 1, i);
      end
    end
    n_vec++;
    if (cfs !== 8'h01 || cfl !== 8'h80) begin n_bad++; $display("FAIL f1_marks got=%b/%b want 00000001/10000000", cfs, cfl); end
    n_vec++;
    if (ir !== 0) begin n_bad++; $display("FAIL f1_in_ready_emit got=%0d cycles high want 0", ir); end
    n_vec++;
    if (frame_count !== 16'd1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL f1_end got=count%0d/valid%b want count1/valid0", frame_count, out_valid);
    end
  endtask

  task automatic test_overlap();
    for (int k = 9; k <= 12; k++) feed(k);
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL f2_lat_edge1 out_valid=%b want 0", out_valid); end
    step();
    collect();
    n_vec++;
    if (got !== 8) begin n_bad++; $display("FAIL f2_count got=%0d want 8", got); end
    for (int i = 0; i < got; i++) begin
      n_vec++;
      if (cv[i] !== 16'(i + 5) || ci[i] !== 3'(i)) begin
        n_bad++; $display("FAIL f2_data[%0d] got=%0d/idx%0d want %0d/idx%0d", i, cv[i], ci[i], i + 5, i);
      end
    end
    n_vec++;
    if (ir !== 0) begin n_bad++; $display("FAIL f2_in_ready_emit got=%0d cycles high want 0", ir); end
    n_vec++;
    if (frame_count !== 16'd2 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL f2_end got=count%0d/ready%b want count2/ready1", frame_count, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int hold;
    for (int k = 13; k <= 16; k++) feed(k);
    got = 0;
    hold = 0;
    for (int t = 0; t < 60 && got < 8; t++) begin
      if (out_valid && sample_index == 3'd3 && hold < 3) begin
        out_ready = 1'b0;
        hold++;
        n_vec++;
        if (sample_out !== 16'd12 || frame_start !== 1'b0 || frame_last !== 1'b0) begin
          n_bad++; $display("FAIL stall_hold[%0d] got=%0d/%b%b want 12/00", hold, sample_out, frame_start, frame_last);
        end
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          cv[got] = sample_out;
          ci[got] = sample_index;
          got++;
        end
      end
      step();
    end
    out_ready = 1'b1;
    n_vec++;
    if (hold !== 3 || got !== 8) begin n_bad++; $display("FAIL bp_counts got=stall%0d/xfer%0d want 3/8", hold, got); end
    for (int i = 0; i < got; i++) begin
      n_vec++;
      if (cv[i] !== 16'(i + 9) || ci[i] !== 3'(i)) begin
        n_bad++; $display("FAIL bp_data[%0d] got=%0d/idx%0d want %0d/idx%0d", i, cv[i], ci[i], i + 9, i);
      end
    end
    n_vec++;
    if (frame_count !== 16'd3) begin n_bad++; $display("FAIL bp_frame_count got=%0d want 3", frame_count); end
  endtask

  task automatic test_reset_mid();
    int early;
    logic seen;
    for (int k = 17; k <= 20; k++) feed(k);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (out_valid && sample_index == 3'd5) seen = 1'b1;
      else step();
    end
    n_vec++;
    if (seen !== 1'b1 || sample_out !== 16'd18) begin n_bad++; $display("FAIL rm_reach got=%b/%0d want 1/18", seen, sample_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || frame_count !== 16'd0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rm_after got=valid%b/count%0d/ready%b want 0/0/1", out_valid, frame_count, in_ready);
    end
    early = 0;
    for (int k = 100; k <= 107; k++) begin
      feed(k);
      if (out_valid) early++;
    end
    step();
    if (out_valid) early++;
    n_vec++;
    if (early !== 0) begin n_bad++; $display("FAIL rm_early_output got=%0d cycles want 0", early); end
    step();
    collect();
    n_vec++;
    if (got !== 8) begin n_bad++; $display("FAIL rm_count got=%0d want 8", got); end
    for (int i = 0; i < got; i++) begin
      n_vec++;
      if (cv[i] !== 16'(i + 100) || ci[i] !== 3'(i)) begin
        n_bad++; $display("FAIL rm_data[%0d] got=%0d/idx%0d want %0d/idx%0d", i, cv[i], ci[i], i + 100, i);
      end
    end
    n_vec++;
    if (frame_count !== 16'd1) begin n_bad++; $display("FAIL rm_frame_count got=%0d want 1", frame_count); end
  endtask

  task automatic test_hop_n();
    int nxt;
    logic acc;
    for (int p = 0; p < 2; p++) begin
      reset = 1'b1;
      step();
      reset = 1'b0;
      nxt = 1;
      got = 0;
      for (int t = 0; t < 400 && got < 16; t++) begin
        h_in_valid = nxt <= 16 && (p == 0 || $urandom_range(1) == 1);
        h_in_sample = 16'(nxt);
        #1;
        acc = h_in_valid && h_in_ready;
        if (h_out_valid) begin
          cv[got] = h_sample_out;
          ci[got] = h_idx;
          got++;
        end
        step();
        if (acc) nxt++;
      end
      h_in_valid = 1'b0;
      n_vec++;
      if (got !== 16) begin n_bad++; $display("FAIL hopn_count pass%0d got=%0d want 16", p, got); end
      for (int i = 0; i < got; i++) begin
        n_vec++;
        if (cv[i] !== 16'(i + 1) || ci[i] !== 3'(i % 8)) begin
          n_bad++; $display("FAIL hopn_data pass%0d [%0d] got=%0d/idx%0d want %0d/idx%0d", p, i, cv[i], ci[i], i + 1, i % 8);
        end
      end
      n_vec++;
      if (h_fc !== 16'd2) begin n_bad++; $display("FAIL hopn_frame_count pass%0d got=%0d want 2", p, h_fc); end
    end
  endtask

  task automatic test_default();
    int nxt, frames, pos, bad;
    logic acc;
    reset = 1'b1;
    step();
    reset = 1'b0;
    nxt = 1;
    frames = 0;
    pos = 0;
    bad = 0;
    for (int t = 0; t < 30000 && frames < 16; t++) begin
      d_in_valid = 1'b1;
      d_in_sample = 16'(nxt);
      #1;
      acc = d_in_ready;
      if (d_out_valid) begin
        if (d_idx !== 10'(pos) || d_sample_out !== 16'(512 * frames + 1 + pos) ||
            d_fs !== (pos == 0) || d_fl !== (pos == 1023)) bad++;
        pos++;
        if (pos == 1024) begin
          n_vec++;
          if (bad !== 0) begin
            n_bad++; $display("FAIL dflt_frame[%0d] got=%0d bad samples want 0 (first=%0d)", frames, bad, 512 * frames + 1);
          end
          pos = 0;
          bad = 0;
          frames++;
        end
      end
      step();
      if (acc) nxt++;
    end
    d_in_valid = 1'b0;
    n_vec++;
    if (frames !== 16 || d_fc !== 16'd16) begin
      n_bad++; $display("FAIL dflt_frames got=%0d/count%0d want 16/16", frames, d_fc);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_overlap();
    test_backpressure();
    test_reset_mid();
    test_hop_n();
    test_default();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
